pwm_duty_decoder: RTL and testbench



---
 rtl/pwm_duty_decoder_pkg.sv | 20 ++
 rtl/pwm_duty_div.sv | 87 ++++++++
 rtl/pwm_duty_decoder.sv | 184 ++++++++++++++++++
 tb/tb_pwm_duty_decoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_duty_decoder_pkg.sv
// Shared definitions for the PWM duty decoder: FSM state codes and the duty scale
// that the on-chip PWM generator also uses.
package pwm_duty_decoder_pkg;

  localparam int DUTY_STEPS = 10;
  localparam int DUTY_W     = 4;

  typedef logic [1:0] dec_state_t;

  localparam dec_state_t ST_IDLE    = 2'd0;
  localparam dec_state_t ST_MEASURE = 2'd1;
  localparam dec_state_t ST_DIVIDE  = 2'd2;
  localparam dec_state_t ST_STUCK   = 2'd3;

  // Duty reported for a constant input level: full scale when stuck high.
  function automatic logic [DUTY_W-1:0] level_duty(input logic lvl);
    return lvl ? DUTY_W'(DUTY_STEPS) : '0;
  endfunction

endpackage

// File: rtl/pwm_duty_div.sv
// Four-iteration restoring divider for the duty ratio; the quotient never exceeds
// DUTY_STEPS, so four quotient bits are enough.
module pwm_duty_div
  import pwm_duty_decoder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W+3:0]  numerator,
  input  logic [CNT_W-1:0]  denominator,
  output logic              busy,
  output logic              done,
  output logic [DUTY_W-1:0] quotient
);

  localparam int NUM_W = CNT_W + 4;

  logic [NUM_W-1:0]  rem_q, rem_d, dsh_q, dsh_d;
  logic [NUM_W-1:0]  rem_in, dsh_in, rem_next;
  logic [DUTY_W-1:0] quo_q, quo_d, quo_in;
  logic [1:0]        step_q, step_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              ge;

  // The first iteration is taken on the start edge itself, so the result is
  // ready (done) three cycles after start.
  always_comb begin
    rem_in   = start ? numerator : rem_q;
    dsh_in   = start ? {1'b0, denominator, 3'b000} : dsh_q;
    quo_in   = start ? '0 : quo_q;
    ge       = (rem_in >= dsh_in);
    rem_next = ge ? (rem_in - dsh_in) : rem_in;

    rem_d  = rem_q;
    dsh_d  = dsh_q;
    quo_d  = quo_q;
    step_d = step_q;
    busy_d = busy_q;
    done_d = 1'b0;

    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      rem_d  = rem_next;
      dsh_d  = dsh_in >> 1;
      quo_d  = {quo_in[DUTY_W-2:0], ge};
      step_d = 2'd2;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = rem_next;
      dsh_d = dsh_in >> 1;
      quo_d = {quo_in[DUTY_W-2:0], ge};
      if (step_q == 2'd0) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        step_d = step_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      dsh_q  <= '0;
      quo_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dsh_q  <= dsh_d;
      quo_q  <= quo_d;
      step_q <= step_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures period and high time of an external PWM input and reports the duty
// in tenths, flagging stuck inputs by timeout and too-short periods as overrun.
module pwm_duty_decoder
  import pwm_duty_decoder_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int MAX_PERIOD = 200,
  parameter int MIN_PERIOD = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [DUTY_W-1:0] duty_tenths,
  output logic              meas_valid,
  output logic              stuck,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MAX_PERIOD - 1);
  localparam logic [CNT_W-1:0] RUN_MIN  = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] RUN_ONE  = CNT_W'(1);

  logic [2:0]        sync_q, sync_d;
  dec_state_t        state_q, state_d;
  logic [CNT_W-1:0]  period_run_q, period_run_d, high_run_q, high_run_d;
  logic [CNT_W-1:0]  per_sh_q, per_sh_d, hi_sh_q, hi_sh_d;
  logic [CNT_W-1:0]  period_cnt_q, period_cnt_d, high_cnt_q, high_cnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              meas_valid_q, meas_valid_d, stuck_q, stuck_d;
  logic              overrun_q, overrun_d;

  logic              s2, s3, rise, fall, timeout, to_stuck;
  logic [CNT_W+3:0]  num;
  logic              div_start, div_busy, div_done;
  logic [DUTY_W-1:0] div_quo;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == RUN_MAX) ? v : v + RUN_ONE;
  endfunction

  assign s2      = sync_q[1];
  assign s3      = sync_q[2];
  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign timeout = (period_run_q == RUN_LAST) & ~rise;
  assign num     = ({4'b0000, high_run_q} << 3) + ({4'b0000, high_run_q} << 1);

  always_comb begin
    sync_d       = {sync_q[1:0], pwm_in};
    state_d      = state_q;
    period_run_d = period_run_q;
    high_run_d   = high_run_q;
    per_sh_d     = per_sh_q;
    hi_sh_d      = hi_sh_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    duty_d       = duty_q;
    stuck_d      = stuck_q;
    meas_valid_d = 1'b0;
    overrun_d    = 1'b0;
    div_start    = 1'b0;
    to_stuck     = 1'b0;

    if (!ena) begin
      state_d      = ST_IDLE;
      period_run_d = '0;
      high_run_d   = '0;
    end else begin
      case (state_q)
        ST_MEASURE, ST_DIVIDE: begin
          if ((state_q == ST_DIVIDE) && !div_busy) state_d = ST_MEASURE;
          if (rise) begin
            if (period_run_q < RUN_MIN) begin
              overrun_d = 1'b1;
            end else begin
              per_sh_d  = period_run_q;
              hi_sh_d   = high_run_q;
              div_start = 1'b1;
              state_d   = ST_DIVIDE;
            end
            period_run_d = RUN_ONE;
            high_run_d   = RUN_ONE;
          end else if (timeout) begin
            to_stuck = 1'b1;
          end else begin
            period_run_d = sat_inc(period_run_q);
            high_run_d   = high_run_q + CNT_W'(s2);
          end
        end
        default: begin
          high_run_d = '0;
          if (rise) begin
            state_d      = ST_MEASURE;
            period_run_d = RUN_ONE;
            high_run_d   = RUN_ONE;
          end else if (timeout) begin
            to_stuck = 1'b1;
          end else if ((state_q == ST_STUCK) && fall) begin
            period_run_d = '0;
          end else begin
            period_run_d = sat_inc(period_run_q);
          end
        end
      endcase

      // Parking the counter at RUN_MAX keeps a steady level from re-reporting;
      // only a falling edge restarts the timeout.
      if (to_stuck) begin
        state_d      = ST_STUCK;
        period_run_d = RUN_MAX;
        high_run_d   = '0;
        period_cnt_d = '0;
        high_cnt_d   = '0;
        duty_d       = level_duty(s2);
        meas_valid_d = 1'b1;
        stuck_d      = 1'b1;
      end

      if (div_done) begin
        period_cnt_d = per_sh_q;
        high_cnt_d   = hi_sh_q;
        duty_d       = div_quo;
        meas_valid_d = 1'b1;
        stuck_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      state_q      <= ST_IDLE;
      period_run_q <= '0;
      high_run_q   <= '0;
      per_sh_q     <= '0;
      hi_sh_q      <= '0;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      duty_q       <= '0;
      meas_valid_q <= 1'b0;
      stuck_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      period_run_q <= period_run_d;
      high_run_q   <= high_run_d;
      per_sh_q     <= per_sh_d;
      hi_sh_q      <= hi_sh_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      duty_q       <= duty_d;
      meas_valid_q <= meas_valid_d;
      stuck_q      <= stuck_d;
      overrun_q    <= overrun_d;
    end
  end

  pwm_duty_div #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (div_start),
    .abort       (~ena),
    .numerator   (num),
    .denominator (period_run_q),
    .busy        (div_busy),
    .done        (div_done),
    .quotient    (div_quo)
  );

  assign period_cnt  = period_cnt_q;
  assign high_cnt    = high_cnt_q;
  assign duty_tenths = duty_q;
  assign meas_valid  = meas_valid_q;
  assign stuck       = stuck_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Scoreboard bench for pwm_duty_decoder: the waveform is described as (period, high)
// segments and expected reports are derived from those segment values.
module tb_pwm_duty_decoder;

  localparam int CNT_W      = 8;
  localparam int MAX_PERIOD = 200;
  localparam int MIN_PERIOD = 6;
  localparam int SYNC_LAT   = 2;
  localparam int DIV_LAT    = 5;
  localparam int STUCK_HOLD = MAX_PERIOD + 30;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] period_cnt, high_cnt;
  logic [3:0]       duty_tenths;
  logic             meas_valid, stuck, overrun;

  pwm_duty_decoder #(
    .CNT_W      (CNT_W),
    .MAX_PERIOD (MAX_PERIOD),
    .MIN_PERIOD (MIN_PERIOD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .pwm_in      (pwm_in),
    .period_cnt  (period_cnt),
    .high_cnt    (high_cnt),
    .duty_tenths (duty_tenths),
    .meas_valid  (meas_valid),
    .stuck       (stuck),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p;
    int h;
    int duty;
    int stk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0, n_bad = 0, cyc = 0;
  int   prev_p = 0, prev_h = 0;
  bit   prev_ok = 1'b0;
  int   exp_ovr = 0, ovr_seen = 0;
  int   last_p = 0, last_h = 0, last_duty = 0;
  bit   arm_lat = 1'b0;
  int   first_mv_cyc = -1, rise_cyc = 0, lat_rise = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic void push_meas(input int p, input int h);
    exp_t e;
    e.p = p; e.h = h; e.duty = (h * 10) / p; e.stk = 0;
    sb.push_back(e);
    last_p = p; last_h = h; last_duty = e.duty;
  endfunction

  // A rising pin edge closes the previous segment: report it or count an overrun.
  function automatic void pin_rise(input bit starts_seg, input int p, input int h);
    if (ena && prev_ok) begin
      if (prev_p < MIN_PERIOD) exp_ovr++;
      else push_meas(prev_p, prev_h);
    end
    prev_ok = ena && starts_seg;
    prev_p  = p;
    prev_h  = h;
  endfunction

  task automatic drive_seg(input int p, input int h, input int rst_at = -1);
    pin_rise(1'b1, p, h);
    rise_cyc = cyc;
    for (int i = 0; i < p; i++) begin
      pwm_in = (i < h);
      if (i == rst_at) begin
        rst_n   = 1'b0;
        prev_ok = 1'b0;
      end
      if (rst_at >= 0 && i == rst_at + 1) begin
        check("rst_mid_period_cnt", int'(period_cnt), 0);
        check("rst_mid_high_cnt", int'(high_cnt), 0);
        check("rst_mid_duty", int'(duty_tenths), 0);
        check("rst_mid_stuck", int'(stuck), 0);
      end
      if (rst_at >= 0 && i == rst_at + 3) rst_n = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  // Long holds (>= STUCK_HOLD) are expected to time out; short ones only follow a stuck report.
  task automatic hold(input bit lvl, input int n);
    exp_t e;
    if (lvl && !pwm_in) pin_rise(1'b0, 0, 0);
    prev_ok = 1'b0;
    if (n >= STUCK_HOLD) begin
      e.p = 0; e.h = 0; e.duty = lvl ? 10 : 0; e.stk = 1;
      sb.push_back(e);
    end
    pwm_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (!ena) check("no_pulse_when_disabled", int'(meas_valid | overrun), 0);
      if (overrun) ovr_seen++;
      if (meas_valid) begin
        if (arm_lat) begin
          first_mv_cyc = cyc;
          arm_lat = 1'b0;
        end
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_meas_valid: got pulse with period_cnt=%0d duty=%0d, expected none (t=%0t)",
                   period_cnt, duty_tenths, $time);
        end else begin
          mon_e = sb.pop_front();
          check("meas_period_cnt", int'(period_cnt), mon_e.p);
          check("meas_high_cnt", int'(high_cnt), mon_e.h);
          check("meas_duty", int'(duty_tenths), mon_e.duty);
          check("meas_stuck", int'(stuck), mon_e.stk);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p, h;
    rst_n = 1'b0; ena = 1'b0; pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_period_cnt", int'(period_cnt), 0);
    check("reset_high_cnt", int'(high_cnt), 0);
    check("reset_duty", int'(duty_tenths), 0);
    check("reset_meas_valid", int'(meas_valid), 0);
    check("reset_stuck", int'(stuck), 0);
    check("reset_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    ena   = 1'b1;

    // Stuck low from reset, then recovery at 70 %.
    hold(1'b0, STUCK_HOLD);
    check("stuck_low_flag", int'(stuck), 1);
    check("stuck_low_duty", int'(duty_tenths), 0);
    check("stuck_low_period", int'(period_cnt), 0);
    repeat (3) drive_seg(10, 7);
    check("stuck_cleared", int'(stuck), 0);
    check("recover_duty", int'(duty_tenths), 7);

    repeat (4) drive_seg(10, 5);
    repeat (2) drive_seg(10, 3);
    repeat (2) drive_seg(10, 9);

    // Stuck high after running PWM.
    hold(1'b1, STUCK_HOLD);
    check("stuck_high_flag", int'(stuck), 1);
    check("stuck_high_duty", int'(duty_tenths), 10);
    hold(1'b0, 5);

    // Overrun burst: outputs must keep the last good measurement.
    repeat (2) drive_seg(10, 5);
    repeat (8) drive_seg(4, 2);
    check("overrun_count", ovr_seen, exp_ovr);
    check("overrun_hold_period", int'(period_cnt), last_p);
    check("overrun_hold_high", int'(high_cnt), last_h);
    check("overrun_hold_duty", int'(duty_tenths), last_duty);
    drive_seg(10, 5);

    // Periods around the minimum.
    drive_seg(6, 3);
    drive_seg(5, 2);
    drive_seg(6, 5);
    drive_seg(10, 5);

    // Reset in the low phase of a long period.
    drive_seg(40, 10, 20);
    repeat (3) drive_seg(10, 5);

    // Enable dropped for two periods, then first-result latency.
    ena = 1'b0;
    repeat (2) drive_seg(10, 5);
    ena = 1'b1;
    arm_lat = 1'b1;
    first_mv_cyc = -1;
    drive_seg(10, 5);
    lat_rise = rise_cyc;
    repeat (2) drive_seg(10, 5);
    check("first_result_latency", first_mv_cyc - lat_rise, 10 + SYNC_LAT + DIV_LAT);

    // Randomised segments, including periods below the minimum.
    for (int k = 0; k < 40; k++) begin
      p = $urandom_range(60, 2);
      h = $urandom_range(p - 1, 1);
      drive_seg(p, h);
    end

    repeat (20) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    check("overrun_total", ovr_seen, exp_ovr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
